// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared encodings for the iterative multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package muldiv_unit_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Operation select as seen on op_div_i.
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Pipeline stall request encoding.
  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

endpackage

// File: rtl/muldiv_negate.sv
// muldiv_negate: conditional two's-complement negate, dout = neg ? -din : din.
// Latency: combinational.
// Backpressure: none.
// Ports: neg (negate enable), din (W-bit value), dout (W-bit result).
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? ((~din) + W'(1)) : din;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative W-bit multiply (shift-add) / divide (restoring), signed or unsigned.
// Latency: ready_o W+1 cycles after accept; 1 cycle for divide by zero.
// Backpressure: caller holds start_i until ready_o; stallreq_o asks the pipeline to stop meanwhile.
// Ports: clk, resetn (sync, active low); start_i/op_div_i/signed_i/opa_i/opb_i request;
//        annul_i flush; busy_o, ready_o, result_o {hi,lo} or {rem,quo}, div_by_zero_o, stallreq_o.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int W  = 32,
  parameter int CW = $clog2(W+1)
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start_i,
  input  logic           op_div_i,
  input  logic           signed_i,
  input  logic [W-1:0]   opa_i,
  input  logic [W-1:0]   opb_i,
  input  logic           annul_i,
  output logic           busy_o,
  output logic           ready_o,
  output logic [2*W-1:0] result_o,
  output logic           div_by_zero_o,
  output logic           stallreq_o
);

  state_t         state_q, state_d;
  logic           accept;

  logic [CW-1:0]  cnt_q;
  logic           op_q;
  logic [W-1:0]   a_q, b_q;
  logic [2*W-1:0] p_q;
  logic           neg_res_q, neg_rem_q, dbz_q;
  logic [2*W-1:0] result_q;

  logic           sign_a, sign_b, div_zero_in, last_step;
  logic [W-1:0]   mag_a, mag_b;

  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     div_shift, div_diff;
  logic           div_ge;
  logic [2*W-1:0] div_next;
  logic [2*W-1:0] step_next;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix;
  logic [2*W-1:0] final_res;

  // ---------------------------------------------------------------- operand prep
  assign sign_a      = signed_i & opa_i[W-1];
  assign sign_b      = signed_i & opb_i[W-1];
  assign div_zero_in = (op_div_i == OP_DIV) && (opb_i == '0);
  assign last_step   = (cnt_q == CW'(W-1));

  muldiv_negate #(.W(W)) u_neg_a (.neg(sign_a), .din(opa_i), .dout(mag_a));
  muldiv_negate #(.W(W)) u_neg_b (.neg(sign_b), .din(opb_i), .dout(mag_b));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // annul_i wins over a simultaneous start_i
        if (start_i && !annul_i) begin
          accept  = 1'b1;
          state_d = div_zero_in ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (annul_i)        state_d = S_IDLE;
        else if (last_step) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o        = (state_q == S_CALC);
  assign ready_o       = resetn && (state_q == S_DONE) && !annul_i;
  assign div_by_zero_o = resetn && (state_q == S_DONE) && !annul_i && dbz_q;
  assign stallreq_o    = (resetn && (busy_o || accept)) ? STOP : NOSTOP;
  assign result_o      = result_q;

  // ---------------------------------------------------------------- step logic
  // Multiply: p_q = {hi, multiplier}; add multiplicand into hi when lsb set, shift right.
  assign mul_sum  = {1'b0, p_q[2*W-1:W]} + {1'b0, (p_q[0] ? a_q : {W{1'b0}})};
  assign mul_next = {mul_sum, p_q[W-1:1]};

  // Divide: p_q = {rem, quotient-in-progress}; shift left, try subtracting divisor,
  // keep the difference only when it does not go negative.
  assign div_shift = p_q[2*W-1:W-1];
  assign div_ge    = (div_shift >= {1'b0, b_q});
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_next  = div_ge ? {div_diff[W-1:0],  p_q[W-2:0], 1'b1}
                            : {div_shift[W-1:0], p_q[W-2:0], 1'b0};

  assign step_next = (op_q == OP_DIV) ? div_next : mul_next;

  // Sign fix-up of the final step's value, captured on entry to DONE.
  muldiv_negate #(.W(2*W)) u_neg_prod (.neg(neg_res_q), .din(step_next),
                                       .dout(prod_fix));
  muldiv_negate #(.W(W))   u_neg_quo  (.neg(neg_res_q), .din(step_next[W-1:0]),
                                       .dout(quo_fix));
  muldiv_negate #(.W(W))   u_neg_rem  (.neg(neg_rem_q), .din(step_next[2*W-1:W]),
                                       .dout(rem_fix));

  assign final_res = (op_q == OP_DIV) ? {rem_fix, quo_fix} : prod_fix;

  // ---------------------------------------------------------------- datapath regs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q     <= '0;
      op_q      <= OP_MUL;
      a_q       <= '0;
      b_q       <= '0;
      p_q       <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      result_q  <= '0;
    end else if (accept) begin
      cnt_q     <= '0;
      op_q      <= op_div_i;
      a_q       <= mag_a;
      b_q       <= mag_b;
      neg_res_q <= sign_a ^ sign_b;
      // remainder follows the dividend's sign
      neg_rem_q <= sign_a;
      dbz_q     <= div_zero_in;
      // dividend seeds the divide, multiplier seeds the multiply
      p_q       <= (op_div_i == OP_DIV) ? {{W{1'b0}}, mag_a} : {{W{1'b0}}, mag_b};
      // divide by zero skips CALC: raw dividend as remainder, all-ones quotient
      if (div_zero_in) result_q <= {opa_i, {W{1'b1}}};
    end else if (state_q == S_CALC) begin
      cnt_q <= cnt_q + CW'(1);
      p_q   <= step_next;
      // an annulled operation must not disturb the previously delivered result
      if (last_step && !annul_i) result_q <= final_res;
    end
  end

endmodule
